// File: rtl/axi_rom_responder.sv
// AXI4 read-only responder for the boot ROM region. It issues one ROM word read per beat,
// answers out-of-range or illegal beats with error responses, and answers every write with SLVERR.
module axi_rom_responder #(
   parameter int                   IdWidth      = 4,
   parameter int                   AddrWidth    = 64,
   parameter logic [AddrWidth-1:0] RomBase      = 64'h1_0000,
   parameter logic [AddrWidth-1:0] RomByteSize  = 64'h1_0000,
   parameter int                   RomAddrWidth = $clog2(RomByteSize / 8)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    ar_valid_i,
   output logic                    ar_ready_o,
   input  logic [IdWidth-1:0]      ar_id_i,
   input  logic [AddrWidth-1:0]    ar_addr_i,
   input  logic [7:0]              ar_len_i,
   input  logic [2:0]              ar_size_i,
   input  logic [1:0]              ar_burst_i,
   output logic                    r_valid_o,
   input  logic                    r_ready_i,
   output logic [IdWidth-1:0]      r_id_o,
   output logic [63:0]             r_data_o,
   output logic [1:0]              r_resp_o,
   output logic                    r_last_o,
   input  logic                    aw_valid_i,
   output logic                    aw_ready_o,
   input  logic [IdWidth-1:0]      aw_id_i,
   input  logic                    w_valid_i,
   output logic                    w_ready_o,
   input  logic                    w_last_i,
   output logic                    b_valid_o,
   input  logic                    b_ready_i,
   output logic [IdWidth-1:0]      b_id_o,
   output logic [1:0]              b_resp_o,
   output logic                    rom_req_o,
   output logic [RomAddrWidth-1:0] rom_addr_o,
   input  logic [63:0]             rom_rdata_i
);

   // state   | meaning
   // IDLE    | waiting for AR or AW
   // RD_REQ  | ROM access cycle for the current beat
   // RD_RESP | R beat presented, waiting for r_ready_i
   // WR_DATA | draining W beats
   // WR_RESP | SLVERR write response presented
   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_RESP, WR_DATA, WR_RESP
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   state_t                 state_q, state_d;
   logic [IdWidth-1:0]     id_q, id_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [2:0]             size_q, size_d;
   logic [1:0]             burst_q, burst_d;

   logic                   legal_cfg;
   logic                   in_range;
   logic                   beat_ok;
   logic [1:0]             beat_resp;
   logic [AddrWidth-1:0]   offset;
   logic [AddrWidth-1:0]   step;
   logic [AddrWidth-1:0]   next_addr;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         id_q    <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         size_q  <= size_d;
         burst_q <= burst_d;
      end
   end

   // The subtraction-based range test stays correct even when an INCR burst wraps the address space.
   always_comb begin
      legal_cfg = (size_q <= 3'd3) && (burst_q == BURST_FIXED || burst_q == BURST_INCR);
      offset    = addr_q - RomBase;
      in_range  = (addr_q >= RomBase) && (offset < RomByteSize);
      beat_ok   = legal_cfg && in_range;
      if (!legal_cfg)
         beat_resp = RESP_SLVERR;
      else if (in_range)
         beat_resp = RESP_OKAY;
      else
         beat_resp = RESP_DECERR;
      step      = AddrWidth'(1) << size_q;
      next_addr = (addr_q & ~(step - AddrWidth'(1))) + step;
   end

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      size_d     = size_q;
      burst_d    = burst_q;
      ar_ready_o = 1'b0;
      aw_ready_o = 1'b0;
      w_ready_o  = 1'b0;
      r_valid_o  = 1'b0;
      r_id_o     = '0;
      r_data_o   = '0;
      r_resp_o   = RESP_OKAY;
      r_last_o   = 1'b0;
      b_valid_o  = 1'b0;
      b_id_o     = '0;
      b_resp_o   = RESP_OKAY;
      rom_req_o  = 1'b0;
      rom_addr_o = '0;
      case (state_q)
         IDLE: begin
            ar_ready_o = !rst_i;
            aw_ready_o = !rst_i && !ar_valid_i;
            if (ar_valid_i && !rst_i) begin
               id_d    = ar_id_i;
               addr_d  = ar_addr_i;
               cnt_d   = ar_len_i;
               size_d  = ar_size_i;
               burst_d = ar_burst_i;
               state_d = RD_REQ;
            end else if (aw_valid_i && !rst_i) begin
               id_d    = aw_id_i;
               state_d = WR_DATA;
            end
         end
         RD_REQ: begin
            rom_req_o  = beat_ok;
            rom_addr_o = RomAddrWidth'(offset >> 3);
            state_d    = RD_RESP;
         end
         RD_RESP: begin
            r_valid_o = 1'b1;
            r_id_o    = id_q;
            r_resp_o  = beat_resp;
            r_data_o  = beat_ok ? rom_rdata_i : 64'd0;
            r_last_o  = (cnt_q == 8'd0);
            if (r_ready_i) begin
               if (cnt_q == 8'd0) begin
                  state_d = IDLE;
               end else begin
                  cnt_d   = cnt_q - 8'd1;
                  addr_d  = (burst_q == BURST_FIXED) ? addr_q : next_addr;
                  state_d = RD_REQ;
               end
            end
         end
         WR_DATA: begin
            w_ready_o = 1'b1;
            if (w_valid_i && w_last_i)
               state_d = WR_RESP;
         end
         WR_RESP: begin
            b_valid_o = 1'b1;
            b_id_o    = id_q;
            b_resp_o  = RESP_SLVERR;
            if (b_ready_i)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
